// File: rtl/la_capture_engine.sv
// Capture controller for the logic analyzer: manages a circular sample buffer with a
// programmable pre-trigger window, and exposes its control registers on the daisy-chained bus.
module la_capture_engine #(
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned SAMPLE_DEPTH = 4096,
  parameter int unsigned ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig_i,
  input  logic [15:0]           addr_i,
  input  logic [15:0]           wdata_i,
  input  logic [15:0]           rdata_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic [15:0]           addr_o,
  output logic [15:0]           wdata_o,
  output logic [15:0]           rdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic                  bram_we_o
);

  typedef enum logic [2:0] {
    StIdle           = 3'd0,
    StMoveToPosition = 3'd1,
    StInPosition     = 3'd2,
    StCapturing      = 3'd3,
    StCaptured       = 3'd4
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(SAMPLE_DEPTH - 1);

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LastIdx) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  state_e                state_q, state_d;
  logic                  req_start_q, start_prev_q, req_stop_q, stop_prev_q;
  logic                  trigger_mode_q;
  logic [ADDR_WIDTH-1:0] trigger_loc_q, read_ptr_q, read_ptr_d, write_ptr_q, write_ptr_d;
  logic [15:0]           addr_q, wdata_q, rdata_q;
  logic                  rw_q, valid_q;

  // Unsigned offset wraps to a large value when addr_i is below BASE_ADDR.
  logic [16:0] offset_full;
  logic [2:0]  offset;
  logic        in_range, bus_wr, bus_rd;
  logic [15:0] reg_rdata;

  assign offset_full = {1'b0, addr_i} - 17'(BASE_ADDR);
  assign offset      = offset_full[2:0];
  assign in_range    = (offset_full < 17'd7);
  assign bus_wr      = valid_i & rw_i & in_range;
  assign bus_rd      = valid_i & ~rw_i & in_range;

  always_comb begin
    reg_rdata = '0;
    unique case (offset)
      3'd0:    reg_rdata = 16'(state_q);
      3'd1:    reg_rdata = 16'(req_start_q);
      3'd2:    reg_rdata = 16'(req_stop_q);
      3'd3:    reg_rdata = 16'(trigger_loc_q);
      3'd4:    reg_rdata = 16'(trigger_mode_q);
      3'd5:    reg_rdata = 16'(read_ptr_q);
      3'd6:    reg_rdata = 16'(write_ptr_q);
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      rdata_q <= bus_rd ? reg_rdata : rdata_i;
      rw_q    <= rw_i;
      valid_q <= valid_i;
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign rw_o    = rw_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_start_q    <= 1'b0;
      start_prev_q   <= 1'b0;
      req_stop_q     <= 1'b0;
      stop_prev_q    <= 1'b0;
      trigger_loc_q  <= '0;
      trigger_mode_q <= 1'b0;
    end else begin
      start_prev_q <= req_start_q;
      stop_prev_q  <= req_stop_q;
      if (bus_wr && offset == 3'd1) req_start_q <= wdata_i[0];
      if (bus_wr && offset == 3'd2) req_stop_q <= wdata_i[0];
      if (bus_wr && state_q == StIdle) begin
        if (offset == 3'd3) begin
          trigger_loc_q <= (17'(wdata_i) >= 17'(SAMPLE_DEPTH)) ? LastIdx
                                                               : wdata_i[ADDR_WIDTH-1:0];
        end
        if (offset == 3'd4) trigger_mode_q <= wdata_i[0];
      end
    end
  end

  logic                  start_pulse, stop_pulse, terminal;
  logic [ADDR_WIDTH-1:0] write_ptr_inc;

  assign start_pulse   = req_start_q & ~start_prev_q;
  assign stop_pulse    = req_stop_q & ~stop_prev_q;
  assign write_ptr_inc = ptr_inc(write_ptr_q);
  // The write at read_ptr-1 closes the ring: buffer then holds exactly SAMPLE_DEPTH samples.
  assign terminal      = (write_ptr_inc == read_ptr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      read_ptr_q  <= '0;
      write_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      read_ptr_q  <= read_ptr_d;
      write_ptr_q <= write_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    read_ptr_d  = read_ptr_q;
    write_ptr_d = write_ptr_q;
    if (stop_pulse) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_pulse) begin
            read_ptr_d  = '0;
            write_ptr_d = '0;
            if (trigger_mode_q)           state_d = StCapturing;
            else if (trigger_loc_q == '0) state_d = StInPosition;
            else                          state_d = StMoveToPosition;
          end
        end
        StMoveToPosition: begin
          write_ptr_d = write_ptr_inc;
          if (write_ptr_inc == trigger_loc_q) state_d = StInPosition;
        end
        StInPosition: begin
          write_ptr_d = write_ptr_inc;
          if (trig_i) state_d = terminal ? StCaptured : StCapturing;
          else        read_ptr_d = ptr_inc(read_ptr_q);
        end
        StCapturing: begin
          write_ptr_d = write_ptr_inc;
          if (terminal) state_d = StCaptured;
        end
        StCaptured: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bram_we_o = 1'b0;
    unique case (state_q)
      StMoveToPosition, StInPosition, StCapturing: bram_we_o = 1'b1;
      default:                                     bram_we_o = 1'b0;
    endcase
  end

  assign bram_addr_o = write_ptr_q;

endmodule

// File: tb/tb_la_capture_engine.sv
// Directed bench for la_capture_engine with a 16-deep sample buffer mapped at bus address 8.
module tb_la_capture_engine;

  localparam int unsigned Base  = 8;
  localparam int unsigned Depth = 16;
  localparam int unsigned Aw    = 4;

  logic          clk = 1'b0, rst = 1'b1, trig_i = 1'b0;
  logic [15:0]   addr_i = '0, wdata_i = '0, rdata_i = '0;
  logic          rw_i = 1'b0, valid_i = 1'b0;
  logic [15:0]   addr_o, wdata_o, rdata_o;
  logic          rw_o, valid_o;
  logic [Aw-1:0] bram_addr_o;
  logic          bram_we_o;

  la_capture_engine #(
    .BASE_ADDR   (Base),
    .SAMPLE_DEPTH(Depth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig_i     (trig_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_i    (rdata_i),
    .rw_i       (rw_i),
    .valid_i    (valid_i),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .rdata_o    (rdata_o),
    .rw_o       (rw_o),
    .valid_o    (valid_o),
    .bram_addr_o(bram_addr_o),
    .bram_we_o  (bram_we_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write monitor: memory writes commit at the next posedge.
  int            wr_cnt = 0;
  logic [Aw-1:0] trig_addr = '0;
  logic [Aw-1:0] wr_q[$];
  always @(negedge clk) begin
    if (bram_we_o) begin
      wr_cnt++;
      wr_q.push_back(bram_addr_o);
      if (trig_i) trig_addr = bram_addr_o;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    tick(1);
    valid_i = 1'b1; rw_i = 1'b1; addr_i = a; wdata_i = d;
    tick(1);
    valid_i = 1'b0; rw_i = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic v);
    tick(1);
    valid_i = 1'b1; rw_i = 1'b0; addr_i = a;
    tick(1);
    d = rdata_o;
    v = valid_o;
    valid_i = 1'b0;
  endtask

  task automatic check_reg(input string tag, input int off, input logic [15:0] exp);
    logic [15:0] d;
    logic        v;
    bus_read(16'(Base + off), d, v);
    check_eq(tag, {16'h0, d}, {16'h0, exp});
  endtask

  // Returns with the start edge registered; the FSM leaves IDLE at the next posedge.
  task automatic do_start();
    bus_write(16'(Base + 1), 16'd0);
    bus_write(16'(Base + 1), 16'd1);
  endtask

  task automatic do_stop();
    bus_write(16'(Base + 2), 16'd1);
    bus_write(16'(Base + 2), 16'd0);
  endtask

  initial begin
    int          base;
    logic [15:0] d;
    logic        v;

    tick(3);
    rst = 1'b0;
    check_eq("reset_valid_o", {31'h0, valid_o}, 32'h0);
    check_eq("reset_rdata_o", {16'h0, rdata_o}, 32'h0);
    check_eq("reset_we", {31'h0, bram_we_o}, 32'h0);
    check_eq("reset_bram_addr", {28'h0, bram_addr_o}, 32'h0);
    check_reg("reset_state", 0, 16'd0);
    check_reg("reset_wptr", 6, 16'd0);

    // Bus register readback and pass-through.
    bus_write(16'(Base + 3), 16'd5);
    bus_read(16'(Base + 3), d, v);
    check_eq("loc_readback", {16'h0, d}, 32'd5);
    check_eq("loc_read_valid", {31'h0, v}, 32'd1);
    rdata_i = 16'hBEEF;
    bus_read(16'd3, d, v);
    check_eq("oor_rdata", {16'h0, d}, 32'hBEEF);
    check_eq("oor_addr_o", {16'h0, addr_o}, 32'd3);
    rdata_i = 16'h0;

    // loc=0, trigger after 20 sliding-window cycles.
    bus_write(16'(Base + 3), 16'd0);
    base = wr_cnt;
    do_start();
    tick(1);
    tick(20);
    trig_i = 1'b1;
    tick(1);
    trig_i = 1'b0;
    tick(20);
    check_eq("t1_writes", 32'(wr_cnt - base), 32'd36);
    check_eq("t1_trig_addr", {28'h0, trig_addr}, 32'd4);
    check_reg("t1_state", 0, 16'd4);
    check_reg("t1_rptr", 5, 16'd4);
    check_reg("t1_wptr", 6, 16'd4);

    // loc=4, trigger 30 cycles after start.
    do_stop();
    check_reg("t2_idle", 0, 16'd0);
    bus_write(16'(Base + 3), 16'd4);
    base = wr_cnt;
    do_start();
    tick(1);
    tick(30);
    trig_i = 1'b1;
    tick(1);
    trig_i = 1'b0;
    tick(20);
    check_eq("t2_writes", 32'(wr_cnt - base), 32'd42);
    check_eq("t2_trig_addr", {28'h0, trig_addr}, 32'd14);
    check_reg("t2_rptr", 5, 16'd10);
    check_reg("t2_wptr", 6, 16'd10);
    check_reg("t2_state", 0, 16'd4);

    // Clamp, then trigger on the IN_POSITION entry cycle: direct to CAPTURED.
    do_stop();
    bus_write(16'(Base + 3), 16'd100);
    check_reg("t3_clamp", 3, 16'd15);
    base = wr_cnt;
    do_start();
    tick(1);
    tick(15);
    trig_i = 1'b1;
    tick(1);
    trig_i = 1'b0;
    tick(5);
    check_eq("t3_writes", 32'(wr_cnt - base), 32'd16);
    check_eq("t3_trig_addr", {28'h0, trig_addr}, 32'd15);
    check_reg("t3_state", 0, 16'd4);
    check_reg("t3_rptr", 5, 16'd0);

    // Immediate mode.
    do_stop();
    bus_write(16'(Base + 4), 16'd1);
    check_reg("t4_mode", 4, 16'd1);
    wr_q.delete();
    do_start();
    tick(22);
    check_eq("t4_writes", 32'(wr_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      check_eq($sformatf("t4_addr%0d", i), {28'h0, wr_q[i]}, 32'(i));
    end
    check_reg("t4_state", 0, 16'd4);
    bus_write(16'(Base + 3), 16'd7);
    check_reg("t4_loc_locked", 3, 16'd15);

    // Stop mid-CAPTURING.
    do_stop();
    do_start();
    tick(6);
    bus_write(16'(Base + 2), 16'd1);
    tick(1);
    check_eq("t5_we_off", {31'h0, bram_we_o}, 32'd0);
    base = wr_cnt;
    tick(4);
    check_eq("t5_no_writes", 32'(wr_cnt - base), 32'd0);
    check_reg("t5_state", 0, 16'd0);
    bus_write(16'(Base + 2), 16'd0);

    // Asynchronous reset mid-IN_POSITION.
    bus_write(16'(Base + 4), 16'd0);
    bus_write(16'(Base + 3), 16'd3);
    do_start();
    tick(7);
    valid_i = 1'b1; rw_i = 1'b0; addr_i = 16'h0100; rdata_i = 16'h1234;
    tick(1);
    check_eq("t6_pre_valid", {31'h0, valid_o}, 32'd1);
    check_eq("t6_pre_we", {31'h0, bram_we_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", {31'h0, valid_o}, 32'd0);
    check_eq("t6_rst_rdata", {16'h0, rdata_o}, 32'd0);
    check_eq("t6_rst_addr_o", {16'h0, addr_o}, 32'd0);
    check_eq("t6_rst_we", {31'h0, bram_we_o}, 32'd0);
    check_eq("t6_rst_bram_addr", {28'h0, bram_addr_o}, 32'd0);
    valid_i = 1'b0; addr_i = '0; rdata_i = '0;
    tick(1);
    rst = 1'b0;
    check_reg("t6_state", 0, 16'd0);
    check_reg("t6_loc", 3, 16'd0);
    check_reg("t6_rptr", 5, 16'd0);
    check_reg("t6_wptr", 6, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
